// File: rtl/mem_backing_store_if.sv
// Mem_ift: cache line refill/writeback bus between L1 and memory.
// Request/reply channels each with valid/ready and a bits bundle.
interface Mem_ift #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  localparam int NB = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] raddr;
  } r_req_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         wmask;
  } w_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
  } r_rsp_t;

  typedef struct packed {
    logic [1:0] bresp;
  } w_rsp_t;

  logic   r_request_valid;
  logic   r_request_ready;
  r_req_t r_request_bits;

  logic   w_request_valid;
  logic   w_request_ready;
  w_req_t w_request_bits;

  logic   r_reply_valid;
  logic   r_reply_ready;
  r_rsp_t r_reply_bits;

  logic   w_reply_valid;
  logic   w_reply_ready;
  w_rsp_t w_reply_bits;

  modport Slave (
    input  r_request_valid, r_request_bits,
    input  w_request_valid, w_request_bits,
    input  r_reply_ready, w_reply_ready,
    output r_request_ready, w_request_ready,
    output r_reply_valid, r_reply_bits,
    output w_reply_valid, w_reply_bits
  );

  modport Master (
    output r_request_valid, r_request_bits,
    output w_request_valid, w_request_bits,
    output r_reply_ready, w_reply_ready,
    input  r_request_ready, w_request_ready,
    input  r_reply_valid, r_reply_bits,
    input  w_reply_valid, w_reply_bits
  );
endinterface

// File: rtl/mem_backing_store.sv
// Line-wide backing memory slave with fixed read/write latency.
// Ports: clk, rst (async high), mem (Mem_ift Slave: req/reply channels).
module mem_backing_store #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int DEPTH_LOG     = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4,
  parameter     INIT_FILE     = ""
) (
  input logic clk,
  input logic rst,
  Mem_ift.Slave mem
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int LINES = 1 << DEPTH_LOG;
  localparam int TOP   = DEPTH_LOG + OFF;

  localparam logic [7:0] RL1 = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WL1 = 8'(WRITE_LATENCY - 1);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 255) begin : g_bad_rl
      $error("READ_LATENCY must be 1..255");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 255) begin : g_bad_wl
      $error("WRITE_LATENCY must be 1..255");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, R_BUSY, R_RESP, W_BUSY, W_RESP
  } state_t;

  state_t state, state_nx;

  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] store [LINES];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [1:0]            bresp_q;

  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         wmask;
  logic [DEPTH_LOG-1:0]  ridx;
  logic [DEPTH_LOG-1:0]  widx;
  logic                  r_oor;
  logic                  w_oor;

  logic w_acc;
  logic r_acc;
  logic busy;

  logic r_rdy;
  logic w_rdy;
  logic r_vld;
  logic w_vld;

  assign raddr = mem.r_request_bits.raddr;
  assign waddr = mem.w_request_bits.waddr;
  assign wdata = mem.w_request_bits.wdata;
  assign wmask = mem.w_request_bits.wmask;

  assign ridx = raddr[TOP-1:OFF];
  assign widx = waddr[TOP-1:OFF];

  generate
    if (ADDR_WIDTH > TOP) begin : g_hi
      assign r_oor = |raddr[ADDR_WIDTH-1:TOP];
      assign w_oor = |waddr[ADDR_WIDTH-1:TOP];
    end else begin : g_nohi
      assign r_oor = 1'b0;
      assign w_oor = 1'b0;
    end
  endgenerate

  // Byte offset within the line has no effect on a line access.
  logic unused_low;
  assign unused_low = ^{raddr[OFF-1:0], waddr[OFF-1:0]};

  // Write wins a same-cycle tie so a victim writeback lands
  // before the refill read of the same line.
  assign w_acc = (state == IDLE) && mem.w_request_valid;
  assign r_acc = (state == IDLE) && mem.r_request_valid
                 && !mem.w_request_valid;
  assign busy  = (state == R_BUSY) || (state == W_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    r_rdy    = 1'b0;
    w_rdy    = 1'b0;
    r_vld    = 1'b0;
    w_vld    = 1'b0;
    unique case (state)
      IDLE: begin
        w_rdy = 1'b1;
        r_rdy = !mem.w_request_valid;
        if (mem.w_request_valid)
          state_nx = (WL1 == 8'd0) ? W_RESP : W_BUSY;
        else if (mem.r_request_valid)
          state_nx = (RL1 == 8'd0) ? R_RESP : R_BUSY;
      end
      R_BUSY: if (cnt == 8'd1) state_nx = R_RESP;
      W_BUSY: if (cnt == 8'd1) state_nx = W_RESP;
      R_RESP: begin
        r_vld = 1'b1;
        if (mem.r_reply_ready) state_nx = IDLE;
      end
      W_RESP: begin
        w_vld = 1'b1;
        if (mem.w_reply_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 8'd0;
      rdata_q <= '0;
      rresp_q <= OKAY;
      bresp_q <= OKAY;
    end else begin
      unique case (1'b1)
        w_acc: begin
          cnt     <= WL1;
          bresp_q <= w_oor ? SLVERR : OKAY;
        end
        r_acc: begin
          cnt     <= RL1;
          rdata_q <= r_oor ? '0 : store[ridx];
          rresp_q <= r_oor ? SLVERR : OKAY;
        end
        busy:    cnt <= cnt - 8'd1;
        default: ;
      endcase
    end
  end

  // Array has no reset: contents survive rst by design.
  always_ff @(posedge clk) begin
    if (w_acc && !w_oor && !rst) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask[i]) store[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign mem.r_request_ready = r_rdy;
  assign mem.w_request_ready = w_rdy;
  assign mem.r_reply_valid   = r_vld;
  assign mem.w_reply_valid   = w_vld;
  assign mem.r_reply_bits    = {rdata_q, rresp_q};
  assign mem.w_reply_bits    = bresp_q;
endmodule

// File: tb/tb_mem_backing_store.sv
// Bench for mem_backing_store: directed plan plus random traffic
// checked against a line-array reference model.
module tb_mem_backing_store;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  Mem_ift #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

  mem_backing_store #(
    .ADDR_WIDTH(32), .DATA_WIDTH(128), .DEPTH_LOG(10),
    .READ_LATENCY(LAT), .WRITE_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem(bus)
  );

  int passed = 0;
  int total  = 0;
  logic [127:0] model [1024];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit oor(input logic [31:0] a);
    return a[31:14] != 18'd0;
  endfunction

  task automatic do_write(input logic [31:0] a,
                          input logic [127:0] d,
                          input logic [15:0] m,
                          input int hold);
    bit ok;
    int lat;
    logic [1:0] eb;
    bus.w_request_valid      = 1'b1;
    bus.w_request_bits.waddr = a;
    bus.w_request_bits.wdata = d;
    bus.w_request_bits.wmask = m;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.w_request_ready) begin ok = 1'b1; break; end
      tick();
    end
    chk("w_accept", 128'(ok), 128'd1);
    tick();
    bus.w_request_valid = 1'b0;
    eb = oor(a) ? 2'b10 : 2'b00;
    if (!oor(a))
      for (int i = 0; i < 16; i++)
        if (m[i]) model[a[13:4]][8*i +: 8] = d[8*i +: 8];
    lat = 1;
    while (!bus.w_reply_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("w_latency", 128'(lat), 128'(LAT));
    chk("bresp", 128'(bus.w_reply_bits.bresp), 128'(eb));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("w_hold_valid", 128'(bus.w_reply_valid), 128'd1);
      chk("w_hold_bresp", 128'(bus.w_reply_bits.bresp), 128'(eb));
      chk("w_hold_rdy",
          128'({bus.w_request_ready, bus.r_request_ready}), 128'd0);
    end
    bus.w_reply_ready = 1'b1;
    tick();
    bus.w_reply_ready = 1'b0;
    #1;
    chk("w_done_valid", 128'(bus.w_reply_valid), 128'd0);
    chk("w_idle_rdy", 128'(bus.w_request_ready), 128'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    bit ok;
    int lat;
    logic [127:0] ed;
    logic [1:0] er;
    bus.r_request_valid      = 1'b1;
    bus.r_request_bits.raddr = a;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.r_request_ready) begin ok = 1'b1; break; end
      tick();
    end
    chk("r_accept", 128'(ok), 128'd1);
    tick();
    bus.r_request_valid = 1'b0;
    ed = oor(a) ? 128'd0 : model[a[13:4]];
    er = oor(a) ? 2'b10 : 2'b00;
    lat = 1;
    while (!bus.r_reply_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("r_latency", 128'(lat), 128'(LAT));
    chk("rdata", bus.r_reply_bits.rdata, ed);
    chk("rresp", 128'(bus.r_reply_bits.rresp), 128'(er));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("r_hold_valid", 128'(bus.r_reply_valid), 128'd1);
      chk("r_hold_rdata", bus.r_reply_bits.rdata, ed);
      chk("r_hold_rdy",
          128'({bus.w_request_ready, bus.r_request_ready}), 128'd0);
    end
    bus.r_reply_ready = 1'b1;
    tick();
    bus.r_reply_ready = 1'b0;
    #1;
    chk("r_done_valid", 128'(bus.r_reply_valid), 128'd0);
    chk("r_idle_rdy", 128'(bus.r_request_ready), 128'd1);
  endtask

  initial begin
    logic [31:0]  a;
    logic [127:0] d;
    logic [15:0]  m;

    rst = 1'b1;
    bus.r_request_valid = 1'b0;
    bus.w_request_valid = 1'b0;
    bus.r_reply_ready   = 1'b0;
    bus.w_reply_ready   = 1'b0;
    bus.r_request_bits  = '0;
    bus.w_request_bits  = '0;
    for (int i = 0; i < 1024; i++) model[i] = 'x;
    tick();
    tick();
    chk("rst_rvalid", 128'(bus.r_reply_valid), 128'd0);
    chk("rst_wvalid", 128'(bus.w_reply_valid), 128'd0);
    chk("rst_rdata", bus.r_reply_bits.rdata, 128'd0);
    chk("rst_rresp", 128'(bus.r_reply_bits.rresp), 128'd0);
    chk("rst_bresp", 128'(bus.w_reply_bits.bresp), 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy",
        128'({bus.w_request_ready, bus.r_request_ready}), 128'd3);
    tick();

    for (int l = 0; l < 16; l++)
      do_write(32'(l) << 4,
               {$urandom, $urandom, $urandom, $urandom},
               16'hFFFF, 0);

    do_write(32'h40, 128'h00112233_44556677_8899AABB_CCDDEEFF,
             16'hFFFF, 0);
    do_read(32'h40, 0);
    chk("t1_line", model[4], 128'h00112233_44556677_8899AABB_CCDDEEFF);

    do_write(32'h40, {128{1'b1}}, 16'h000F, 0);
    do_read(32'h4C, 0);
    chk("t2_line", model[4], 128'h00112233_44556677_8899AABB_FFFFFFFF);

    bus.r_request_valid      = 1'b1;
    bus.r_request_bits.raddr = 32'h80;
    bus.w_request_valid      = 1'b1;
    bus.w_request_bits.waddr = 32'h80;
    #1;
    chk("prio_rrdy", 128'(bus.r_request_ready), 128'd0);
    chk("prio_wrdy", 128'(bus.w_request_ready), 128'd1);
    do_write(32'h80, 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0,
             16'hFFFF, 1);
    do_read(32'h80, 0);

    do_read(32'h0001_0000, 0);
    do_write(32'h0001_0000, {$urandom, $urandom, $urandom, $urandom},
             16'hFFFF, 0);
    do_read(32'h0, 0);

    do_read(32'h40, 7);

    bus.r_request_valid      = 1'b1;
    bus.r_request_bits.raddr = 32'h80;
    #1;
    chk("rst_t_accept", 128'(bus.r_request_ready), 128'd1);
    tick();
    bus.r_request_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_t_rvalid", 128'(bus.r_reply_valid), 128'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst_t_norep", 128'(bus.r_reply_valid), 128'd0);
      chk("rst_t_rrdy", 128'(bus.r_request_ready), 128'd1);
    end
    do_read(32'h80, 0);

    for (int n = 0; n < 60; n++) begin
      a = {$urandom_range(0, 15), 4'(n)} & 32'hFF;
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0001_0000;
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 16'($urandom);
        if ($urandom_range(0, 9) == 0) m = 16'h0000;
        do_write(a, d, m, $urandom_range(0, 3));
      end else begin
        do_read(a, $urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
